// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: top-level sequencer for the template-match search.
// Walks a NUM_TILE_X x NUM_TILE_Y grid of 80x80 tiles, hands each tile to
// the window buffer (enable/ack, then address generation from the buffer's
// row/word requests), counts the 65x65 in-order correlation scores per tile
// and keeps the global maximum score with its absolute pixel coordinates.
// Optional watchdog: define WINDOW_SCAN_TIMEOUT_EN to enable it; otherwise
// err is tied low.
module window_scan_ctrl #(
    parameter int ADDR_W         = 20,
    parameter int IMG_W_WORDS    = 80,
    parameter int NUM_TILE_X     = 4,
    parameter int NUM_TILE_Y     = 4,
    parameter int STEP_ROWS      = 64,
    parameter int STEP_WORDS     = 16,
    parameter int POS_PER_TILE   = 4225
`ifdef WINDOW_SCAN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              wh_en,
    input  logic              wh_ack,
    input  logic [6:0]        wh_row,
    input  logic [6:0]        wh_col,
    output logic [31:0]       wh_data,
    input  logic              wh_window_ready,
    input  logic              wh_done,
    input  logic              corr_score_valid,
    input  logic [31:0]       corr_score,
    output logic [31:0]       best_score,
    output logic [15:0]       best_x,
    output logic [15:0]       best_y
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_LOAD, S_SCAN, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       tile_x_q, tile_x_d, tile_y_q, tile_y_d;
    logic [15:0]       score_cnt_q, score_cnt_d;
    logic [6:0]        pos_r_q, pos_r_d, pos_c_q, pos_c_d;
    logic              whdone_q, whdone_d;
    logic [31:0]       best_score_q, best_score_d;
    logic [15:0]       best_x_q, best_x_d, best_y_q, best_y_d;
    logic [ADDR_W-1:0] addr_calc;
    logic              score_take;
`ifdef WINDOW_SCAN_TIMEOUT_EN
    logic [15:0]       wd_q, wd_d;
    logic              err_q, err_d;
    logic              wd_active, wd_kick;
`endif

    // Image word address of the buffer's current request within this tile.
    always_comb begin
        addr_calc = ADDR_W'(32'(base_q)
                    + (32'(tile_y_q) * 32'(STEP_ROWS) + 32'(wh_row)) * 32'(IMG_W_WORDS)
                    + 32'(tile_x_q) * 32'(STEP_WORDS) + 32'(wh_col));
    end

    assign busy       = (state_q == S_REQ) || (state_q == S_LOAD) ||
                        (state_q == S_SCAN) || (state_q == S_NEXT);
    assign done       = (state_q == S_DONE);
    assign wh_en      = (state_q == S_REQ);
    assign mem_rd     = (state_q == S_LOAD);
    assign mem_addr   = (state_q == S_LOAD) ? addr_calc : '0;
    assign wh_data    = mem_rdata;
    assign best_score = best_score_q;
    assign best_x     = best_x_q;
    assign best_y     = best_y_q;
`ifdef WINDOW_SCAN_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

    // Scores past the per-tile count are dropped without being compared.
    assign score_take = (state_q == S_SCAN) && corr_score_valid &&
                        (score_cnt_q < 16'(POS_PER_TILE));

    // Next-state and datapath update for the scan sequencer.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        tile_x_d     = tile_x_q;
        tile_y_d     = tile_y_q;
        score_cnt_d  = score_cnt_q;
        pos_r_d      = pos_r_q;
        pos_c_d      = pos_c_q;
        whdone_d     = whdone_q;
        best_score_d = best_score_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
`ifdef WINDOW_SCAN_TIMEOUT_EN
        err_d        = err_q;
        wd_d         = '0;
        wd_active    = 1'b0;
        wd_kick      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d       = img_base;
                    tile_x_d     = '0;
                    tile_y_d     = '0;
                    score_cnt_d  = '0;
                    pos_r_d      = '0;
                    pos_c_d      = '0;
                    whdone_d     = 1'b0;
                    best_score_d = '0;
                    best_x_d     = '0;
                    best_y_d     = '0;
`ifdef WINDOW_SCAN_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (wh_ack) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (wh_done) whdone_d = 1'b1;
                if (wh_window_ready) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (wh_done) whdone_d = 1'b1;
                if (score_take) begin
                    score_cnt_d = score_cnt_q + 16'd1;
                    if (pos_c_q == 7'd64) begin
                        pos_c_d = '0;
                        pos_r_d = pos_r_q + 7'd1;
                    end else begin
                        pos_c_d = pos_c_q + 7'd1;
                    end
                    // Strict compare: ties keep the earlier position.
                    if (corr_score > best_score_q) begin
                        best_score_d = corr_score;
                        best_x_d     = tile_x_q * 16'(STEP_WORDS * 4) + {9'd0, pos_c_q};
                        best_y_d     = tile_y_q * 16'(STEP_ROWS) + {9'd0, pos_r_q};
                    end
                end
                if ((score_cnt_q == 16'(POS_PER_TILE)) && (whdone_q || wh_done))
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                score_cnt_d = '0;
                pos_r_d     = '0;
                pos_c_d     = '0;
                whdone_d    = 1'b0;
                if ((tile_x_q == 16'(NUM_TILE_X - 1)) && (tile_y_q == 16'(NUM_TILE_Y - 1))) begin
                    tile_x_d = '0;
                    tile_y_d = '0;
                    state_d  = S_DONE;
                end else if (tile_x_q == 16'(NUM_TILE_X - 1)) begin
                    tile_x_d = '0;
                    tile_y_d = tile_y_q + 16'd1;
                    state_d  = S_REQ;
                end else begin
                    tile_x_d = tile_x_q + 16'd1;
                    state_d  = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef WINDOW_SCAN_TIMEOUT_EN
        // Watchdog: any handshake activity or state change restarts it.
        wd_active = (state_q == S_REQ) || (state_q == S_LOAD) || (state_q == S_SCAN);
        wd_kick   = wh_ack || wh_window_ready || corr_score_valid || (state_d != state_q);
        if (wd_active && !wd_kick) begin
            if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
`endif
    end

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            score_cnt_q  <= '0;
            pos_r_q      <= '0;
            pos_c_q      <= '0;
            whdone_q     <= 1'b0;
            best_score_q <= '0;
            best_x_q     <= '0;
            best_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            tile_x_q     <= tile_x_d;
            tile_y_q     <= tile_y_d;
            score_cnt_q  <= score_cnt_d;
            pos_r_q      <= pos_r_d;
            pos_c_q      <= pos_c_d;
            whdone_q     <= whdone_d;
            best_score_q <= best_score_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
        end
    end

`ifdef WINDOW_SCAN_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 2x2 tile grid: reset values,
// address generation, data forwarding, best-score tracking with ties and
// over-count scores, start-while-busy, mid-scan reset and done timing.
module tb_window_scan_ctrl;
    localparam int ADDR_W = 20;
    localparam int NTX    = 2;
    localparam int NTY    = 2;
    localparam int POS    = 4225;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] img_base;
    logic              busy, done, err, mem_rd, wh_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata, wh_data, corr_score, best_score;
    logic              wh_ack, wh_window_ready, wh_done, corr_score_valid;
    logic [6:0]        wh_row, wh_col;
    logic [15:0]       best_x, best_y;

    always #5 clk = ~clk;

    window_scan_ctrl #(.NUM_TILE_X(NTX), .NUM_TILE_Y(NTY)) dut (
        .clk(clk), .rst(rst), .start(start), .img_base(img_base),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .wh_en(wh_en), .wh_ack(wh_ack), .wh_row(wh_row), .wh_col(wh_col),
        .wh_data(wh_data), .wh_window_ready(wh_window_ready), .wh_done(wh_done),
        .corr_score_valid(corr_score_valid), .corr_score(corr_score),
        .best_score(best_score), .best_x(best_x), .best_y(best_y)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    // reference model state
    int exp_base;
    logic [31:0] eb;
    int ex, ey;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (wh_en === 1'b1 && wh_ack === 1'b1) hs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string t;
        logic [31:0] v;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            v = exp_q.pop_front();
            chk(t, obs, v);
        end
    endtask

    function automatic logic [31:0] exp_addr(int r, int c, int tx, int ty);
        int v;
        v = exp_base + (ty * 64 + r) * 80 + tx * 16 + c;
        return 32'(v) & 32'h000F_FFFF;
    endfunction

    function automatic logic [31:0] score_of(int scan, int tx, int ty, int i);
        if (scan == 1) begin
            if (tx == 0 && ty == 0 && (i == 130 || i == 200)) return 32'd900;
            return 32'd5;
        end
        if (tx == 1 && ty == 1 && i == 0) return 32'd7777;
        if (tx == 1 && ty == 0 && i == 4224) return 32'd7000;
        return 32'(i % 97);
    endfunction

    task automatic start_scan(input logic [ADDR_W-1:0] base);
        img_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_base = int'(base);
        eb = 32'd0; ex = 0; ey = 0;
        chk("start_latency_wh_en", {31'd0, wh_en}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("err_after_start", {31'd0, err}, 32'd0);
    endtask

    task automatic run_tile(input int scan, input int tx, input int ty,
                            input bit late, input bit extras, input bit last);
        logic [31:0] s;
        for (int k = 0; k < 20 && wh_en !== 1'b1; k++) tick();
        chk("wh_en_request", {31'd0, wh_en}, 32'd1);
        wh_ack = 1'b1;
        tick();
        wh_ack = 1'b0;
        chk("mem_rd_load", {31'd0, mem_rd}, 32'd1);
        if (scan == 2 && tx == 0 && ty == 0) begin
            // start while busy must not resample img_base
            img_base = 20'h03000;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("busy_start_ignored", {31'd0, busy}, 32'd1);
        end
        wh_row = 7'd0; wh_col = 7'd0; #1;
        push($sformatf("addr_t%0d%0d_r0c0", tx, ty), exp_addr(0, 0, tx, ty));
        pop_chk({12'd0, mem_addr});
        wh_row = 7'd79; wh_col = 7'd19; #1;
        push($sformatf("addr_t%0d%0d_r79c19", tx, ty), exp_addr(79, 19, tx, ty));
        pop_chk({12'd0, mem_addr});
        if (scan == 1 && tx == 0 && ty == 0) begin
            wh_row = 7'd2; wh_col = 7'd3; #1;
            push("addr_0x1a3", 32'h0000_01A3);
            pop_chk({12'd0, mem_addr});
            tick();
            mem_rdata = 32'hCAFE_01A3; #1;
            push("wh_data_fwd", 32'hCAFE_01A3);
            pop_chk(wh_data);
        end
        wh_window_ready = 1'b1;
        tick();
        wh_window_ready = 1'b0;
        chk("mem_rd_scan", {31'd0, mem_rd}, 32'd0);
        for (int i = 0; i < POS; i++) begin
            s = score_of(scan, tx, ty, i);
            corr_score_valid = 1'b1;
            corr_score = s;
            wh_done = (!late && i == 10);
            if (s > eb) begin
                eb = s;
                ex = tx * 64 + i % 65;
                ey = ty * 64 + i / 65;
            end
            tick();
        end
        corr_score_valid = 1'b0;
        wh_done = 1'b0;
        if (extras) begin
            for (int e = 0; e < 3; e++) begin
                corr_score_valid = 1'b1;
                corr_score = 32'hFFFF_FFFF;
                tick();
            end
            corr_score_valid = 1'b0;
        end
        push($sformatf("best_score_t%0d%0d", tx, ty), eb);
        pop_chk(best_score);
        push($sformatf("best_x_t%0d%0d", tx, ty), 32'(ex));
        pop_chk({16'd0, best_x});
        push($sformatf("best_y_t%0d%0d", tx, ty), 32'(ey));
        pop_chk({16'd0, best_y});
        if (late) begin
            wh_done = 1'b1;
            tick();
            wh_done = 1'b0;
        end else begin
            tick();
        end
        chk("busy_in_next", {31'd0, busy}, 32'd1);
        chk("done_in_next", {31'd0, done}, 32'd0);
        if (last) begin
            tick();
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            tick();
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int d0, h0;
        rst = 1'b1; start = 1'b0; img_base = '0; mem_rdata = '0;
        wh_ack = 1'b0; wh_row = '0; wh_col = '0; wh_window_ready = 1'b0;
        wh_done = 1'b0; corr_score_valid = 1'b0; corr_score = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_wh_en", {31'd0, wh_en}, 32'd0);
        chk("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
        chk("rst_best_score", best_score, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_wh_en", {31'd0, wh_en}, 32'd0);

        // scan 1: ties and over-count scores in tile (0,0)
        d0 = done_cnt; h0 = hs_cnt;
        start_scan(20'h00100);
        run_tile(1, 0, 0, 1'b1, 1'b1, 1'b0);
        run_tile(1, 1, 0, 1'b0, 1'b0, 1'b0);
        run_tile(1, 0, 1, 1'b0, 1'b0, 1'b0);
        run_tile(1, 1, 1, 1'b1, 1'b0, 1'b1);
        push("scan1_best_score", 32'd900); pop_chk(best_score);
        push("scan1_best_x", 32'd0);      pop_chk({16'd0, best_x});
        push("scan1_best_y", 32'd2);      pop_chk({16'd0, best_y});
        chk("scan1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("scan1_handshakes", 32'(hs_cnt - h0), 32'd4);
        repeat (5) tick();
        chk("scan1_best_hold", best_score, 32'd900);

        // reset in the middle of a tile scan
        d0 = done_cnt;
        start_scan(20'h00100);
        for (int k = 0; k < 20 && wh_en !== 1'b1; k++) tick();
        wh_ack = 1'b1; tick(); wh_ack = 1'b0;
        wh_window_ready = 1'b1; tick(); wh_window_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            corr_score_valid = 1'b1;
            corr_score = (i == 3) ? 32'd900 : 32'd1;
            tick();
        end
        corr_score_valid = 1'b0;
        chk("midscan_best_before_rst", best_score, 32'd900);
        rst = 1'b1; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_best_score", best_score, 32'd0);
        chk("midrst_best_x", {16'd0, best_x}, 32'd0);
        chk("midrst_best_y", {16'd0, best_y}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_wh_en_idle", {31'd0, wh_en}, 32'd0);
        chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("midrst_busy_after", {31'd0, busy}, 32'd0);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        // scan 2: maximum in the last tile, wrap checks in tile (1,0)
        d0 = done_cnt; h0 = hs_cnt;
        start_scan(20'h02000);
        run_tile(2, 0, 0, 1'b0, 1'b0, 1'b0);
        run_tile(2, 1, 0, 1'b0, 1'b0, 1'b0);
        run_tile(2, 0, 1, 1'b1, 1'b0, 1'b0);
        run_tile(2, 1, 1, 1'b1, 1'b1, 1'b1);
        push("scan2_best_score", 32'd7777); pop_chk(best_score);
        push("scan2_best_x", 32'd64);       pop_chk({16'd0, best_x});
        push("scan2_best_y", 32'd64);       pop_chk({16'd0, best_y});
        chk("scan2_done_count", 32'(done_cnt - d0), 32'd1);
        chk("scan2_handshakes", 32'(hs_cnt - h0), 32'd4);
        chk("scan2_err", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/window_scan_ctrl.md
Name: window_scan_ctrl

Overview:
- Top-level sequencer for the template-match search datapath.
- Steps an 80x80 tile grid across the stored image and drives the 80x80 window buffer through each tile: enable/ack handshake, then address generation from the buffer's row/word requests.
- Counts the 65x65 in-order correlation scores returned for each tile.
- Reports the global best (maximum) score and its absolute pixel coordinates.

Parameters:
- ADDR_W, 20, memory word address width.
- IMG_W_WORDS, 80, image row pitch in 32-bit words (4 px/word).
- NUM_TILE_X, 4, tiles per image row.
- NUM_TILE_Y, 4, tiles per image column.
- STEP_ROWS, 64, vertical tile stride in pixel rows.
- STEP_WORDS, 16, horizontal tile stride in words (64 px).
- POS_PER_TILE, 4225, scores per tile (65x65).
- TIMEOUT_CYCLES, 65535, watchdog limit (optional feature only).

Ports:
- clk in 1 — clock, all logic posedge.
- rst in 1 — asynchronous, active-high reset.
- start in 1 — one-cycle pulse; begins a full-image scan.
- img_base in ADDR_W — word address of pixel (0,0); sampled on accepted start.
- busy out 1 — high from accepted start until done.
- done out 1 — one-cycle pulse, scan complete.
- err out 1 — sticky watchdog error, cleared by next accepted start (optional feature only).
- mem_addr out ADDR_W — word read address to image memory.
- mem_rd out 1 — read strobe.
- mem_rdata in 32 — read data, valid exactly 1 cycle after mem_rd.
- wh_en out 1 — load request to window buffer.
- wh_ack in 1 — buffer accepted load request.
- wh_row in 7 — buffer's requested row, 0..79.
- wh_col in 7 — buffer's requested word, 0..19.
- wh_data out 32 — mem_rdata forwarded unregistered.
- wh_window_ready in 1 — buffer presenting a 16x16 window.
- wh_done in 1 — buffer finished last window of tile.
- corr_score_valid in 1 — correlator score strobe, in window order.
- corr_score in 32 — unsigned score.
- best_score out 32 — running maximum.
- best_x out 16 — pixel column of best window's top-left.
- best_y out 16 — pixel row of best window's top-left.

Behaviour:
- Reset: state IDLE; busy, done, err, mem_rd, wh_en = 0; mem_addr = 0; best_score = 0; best_x = best_y = 0; tile_x, tile_y, score_cnt, pos_r, pos_c = 0. Reset mid-scan aborts immediately; no done is issued.
- IDLE: start latches img_base, clears best_*, tile counters and err -> REQ. start while busy is ignored.
- REQ: wh_en = 1 until wh_ack. On wh_ack -> LOAD (same edge).
- LOAD, fetch phase:
  - mem_rd = 1 every cycle.
  - mem_addr = img_base + (tile_y*STEP_ROWS + wh_row)*IMG_W_WORDS + tile_x*STEP_WORDS + wh_col, computed combinationally, truncated to ADDR_W.
  - First wh_window_ready -> SCAN; mem_rd = 0 from then on.
- SCAN:
  - Each corr_score_valid increments score_cnt and advances (pos_r, pos_c) row-major, pos_c wrapping 64->0 with pos_r increment.
  - If corr_score > best_score (strictly), update best_score, best_x = tile_x*64 + pos_c, best_y = tile_y*64 + pos_r. Update is visible the cycle after the strobe.
  - Ties keep the earlier position.
  - Exit when score_cnt == POS_PER_TILE and wh_done has been seen (either order, sticky flag) -> NEXT.
- NEXT (1 cycle):
  - Clear score_cnt, pos, wh_done flag.
  - tile_x wraps NUM_TILE_X-1 -> 0 with tile_y increment.
  - Last tile (NUM_TILE_X-1, NUM_TILE_Y-1) -> DONE; else -> REQ.
- DONE: done = 1 for one cycle, busy drops the same cycle -> IDLE. best_* hold until next start.
- Scores arriving in IDLE/REQ/LOAD/NEXT/DONE are ignored.
- Scores beyond POS_PER_TILE in SCAN are ignored: no count, no compare.
- Start latency: wh_en is high the cycle after the start pulse.

Optional Feature:
- WINDOW_SCAN_TIMEOUT_EN defined:
  - 16-bit watchdog, cleared by any of wh_ack, wh_window_ready, corr_score_valid, or a state change.
  - Counts in REQ/LOAD/SCAN.
  - On reaching TIMEOUT_CYCLES: err = 1 (sticky), go to IDLE without done, busy = 0.
- Undefined: no watchdog; err is tied 0.

Test Plan:
- Reset held mid-SCAN, released -> all outputs at reset values, state IDLE, no done.
- start with img_base = 0x100, NUM_TILE_X = NUM_TILE_Y = 1; buffer model requests row 2, word 3 -> mem_addr = 0x100 + 2*80 + 3 = 0x1A3; wh_data equals mem_rdata 1 cycle later.
- Tile (1,0) loading, wh_row = 0, wh_col = 0 -> mem_addr = img_base + 16; tile (0,1) -> img_base + 64*80.
- Single tile, scores all 5 except 900 at index 130 and 900 again at index 200 -> best_score = 900, best_x = 0, best_y = 2; done 1 cycle after NEXT.
- 2x2 grid, max 7777 at tile (1,1) index 0 -> best_x = 64, best_y = 64; exactly 4 wh_en handshakes; single done pulse.
- WINDOW_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES = 100, wh_ack never asserted -> err = 1, busy = 0 at cycle 100 after REQ entry, no done; next start clears err.
